cgra_line_packer: RTL and testbench

//  Result-side stage between cgra_shell and the requestor's write path. Accepts the CGRA's

---
 rtl/cgra_line_packer_if.sv | 31 +++
 rtl/cgra_line_packer.sv | 129 ++++++++++++
 tb/tb_cgra_line_packer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cgra_line_packer_if.sv
// Result-word input and cache-line output handshakes of the CGRA line packer.
// The slave modport is the packer itself; master is the side that drives it.
interface cgra_line_packer_if #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 512
);
  localparam int WPL  = LINE_W / WORD_W;
  localparam int NW_W = $clog2(WPL) + 1;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [LINE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [NW_W-1:0]   out_nwords;
  logic              out_last;
  logic [31:0]       line_count;
  logic              busy;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_nwords, out_last, line_count, busy
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_nwords, out_last, line_count, busy
  );
endinterface

// File: rtl/cgra_line_packer.sv
// Packs narrow CGRA result words little-endian into cache lines, queues full or
// flushed lines and hands them to the write path in order.
module cgra_line_packer #(
  parameter int WORD_W    = 32,
  parameter int LINE_W    = 512,
  parameter int OUT_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cgra_line_packer_if.slave  bus
);
  localparam int WPL   = LINE_W / WORD_W;
  localparam int CNT_W = $clog2(WPL) + 1;
  localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int QC_W  = $clog2(OUT_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WPL - 1);

  typedef enum logic [1:0] {EMPTY, FILL, FLUSH_WAIT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, wr_cnt;
  logic [LINE_W-1:0] acc, acc_next, acc_merged;
  logic              ready_en;

  logic [LINE_W-1:0] q_data   [OUT_DEPTH];
  logic [CNT_W-1:0]  q_nwords [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] q_last;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [QC_W-1:0]   q_cnt;
  logic [31:0]       line_count_q;

  logic q_full, q_empty, flush_pend, in_ready_int, out_valid_int;
  logic accept, pop, push, slot_free, close_req, full_line;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign q_full        = (q_cnt == QC_W'(OUT_DEPTH));
  assign q_empty       = (q_cnt == '0);
  assign flush_pend    = (state == FLUSH_WAIT);
  assign out_valid_int = !q_empty;

  // ready_en holds in_ready low until the first clock after reset release;
  // the last word of a line is refused only when the queue has no room for it.
  assign in_ready_int = ready_en & !flush_pend & !(q_full & (cnt == LAST_IDX));
  assign accept       = bus.in_valid & in_ready_int;
  assign pop          = out_valid_int & bus.out_ready;

  always_comb begin
    acc_merged = acc;
    wr_cnt     = cnt;
    if (accept) begin
      acc_merged[cnt[IDX_W-1:0]*WORD_W +: WORD_W] = bus.in_data;
      wr_cnt = cnt + CNT_W'(1);
    end
  end

  // A same-cycle pop frees a slot, so a pending flush can push on that edge.
  always_comb begin
    full_line  = accept & (cnt == LAST_IDX);
    close_req  = (bus.flush | flush_pend) & (wr_cnt != '0);
    slot_free  = !q_full | pop;
    push       = (full_line | close_req) & slot_free;
    state_next = state;
    cnt_next   = wr_cnt;
    acc_next   = acc_merged;
    if (push) begin
      state_next = EMPTY;
      cnt_next   = '0;
      acc_next   = '0;
    end else if (close_req) begin
      state_next = FLUSH_WAIT;
    end else if (wr_cnt != '0) begin
      state_next = FILL;
    end else begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      cnt      <= '0;
      acc      <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      acc      <= acc_next;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q_cnt        <= '0;
      line_count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr       <= ptr_inc(rd_ptr);
        line_count_q <= line_count_q + 32'd1;
      end
      if (push && !pop)      q_cnt <= q_cnt + QC_W'(1);
      else if (!push && pop) q_cnt <= q_cnt - QC_W'(1);
    end
  end

  // Queue storage needs no reset: entries are only visible while q_cnt covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr]   <= acc_merged;
      q_nwords[wr_ptr] <= wr_cnt;
      q_last[wr_ptr]   <= close_req;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_int;
  assign bus.out_data   = out_valid_int ? q_data[rd_ptr]   : '0;
  assign bus.out_nwords = out_valid_int ? q_nwords[rd_ptr] : '0;
  assign bus.out_last   = out_valid_int ? q_last[rd_ptr]   : 1'b0;
  assign bus.line_count = line_count_q;
  assign bus.busy       = (cnt != '0) | !q_empty | flush_pend;
endmodule

// File: tb/tb_cgra_line_packer.sv
// Directed bench for cgra_line_packer: packing, flush corner cases, back-pressure
// with a full queue, and reset in the middle of a job.
module tb_cgra_line_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  cgra_line_packer_if #(.WORD_W(32), .LINE_W(512)) bus ();

  cgra_line_packer #(.WORD_W(32), .LINE_W(512), .OUT_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] mkLine(input logic [31:0] base, input int n);
    logic [511:0] l = '0;
    for (int k = 0; k < n; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] w);
    int guard = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready) begin
      if (guard > 50) begin
        checkOutput("accept_timeout", 512'd0, 512'd1);
        break;
      end
      step();
      guard++;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulseFlush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic doReset();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    rst_n = 1'b0;
    step();
    step();
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_line_count", bus.line_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready_low", bus.in_ready, 0);
    step();
    checkOutput("rel_in_ready_high", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;

    // 1: one full line with out_ready held high
    doReset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(32'(i + 1));
    checkOutput("t1_no_early_valid", bus.out_valid, 0);
    applyStimulus(32'h10);
    checkOutput("t1_valid", bus.out_valid, 1);
    checkOutput("t1_lo_word", bus.out_data[31:0], 32'h1);
    checkOutput("t1_hi_word", bus.out_data[511:480], 32'h10);
    checkOutput("t1_line", bus.out_data, mkLine(32'h1, 16));
    checkOutput("t1_nwords", bus.out_nwords, 16);
    checkOutput("t1_last", bus.out_last, 0);
    step();
    checkOutput("t1_popped", bus.out_valid, 0);
    checkOutput("t1_count", bus.line_count, 1);
    bus.out_ready = 1'b0;

    // 2: partial line closed by flush
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(32'hA0 + 32'(i));
    checkOutput("t2_busy_fill", bus.busy, 1);
    pulseFlush();
    checkOutput("t2_valid", bus.out_valid, 1);
    checkOutput("t2_line", bus.out_data, mkLine(32'hA0, 5));
    checkOutput("t2_nwords", bus.out_nwords, 5);
    checkOutput("t2_last", bus.out_last, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("t2_busy_idle", bus.busy, 0);
    checkOutput("t2_count", bus.line_count, 1);

    // 3: back-pressure, 47th word accepted and 48th stalled
    doReset();
    for (int i = 0; i < 47; i++) applyStimulus(32'h300 + 32'(i));
    checkOutput("t3_ready_low", bus.in_ready, 0);
    bus.in_data  = 32'h32F;
    bus.in_valid = 1'b1;
    step(); step(); step();
    checkOutput("t3_still_stalled", bus.in_ready, 0);
    checkOutput("t3_line_a", bus.out_data, mkLine(32'h300, 16));
    bus.out_ready = 1'b1;
    step();
    checkOutput("t3_ready_back", bus.in_ready, 1);
    checkOutput("t3_line_b", bus.out_data, mkLine(32'h310, 16));
    step();
    bus.in_valid = 1'b0;
    checkOutput("t3_line_c", bus.out_data, mkLine(32'h320, 16));
    checkOutput("t3_c_nwords", bus.out_nwords, 16);
    checkOutput("t3_c_last", bus.out_last, 0);
    step();
    bus.out_ready = 1'b0;
    checkOutput("t3_count", bus.line_count, 3);
    checkOutput("t3_drained", bus.out_valid, 0);
    checkOutput("t3_busy", bus.busy, 0);

    // 4: flush together with the 16th word, then an idle flush
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(32'h400 + 32'(i));
    bus.in_data = 32'h40F; bus.in_valid = 1'b1; bus.flush = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    checkOutput("t4_line", bus.out_data, mkLine(32'h400, 16));
    checkOutput("t4_nwords", bus.out_nwords, 16);
    checkOutput("t4_last", bus.out_last, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("t4_single_line", bus.out_valid, 0);
    pulseFlush();
    step();
    checkOutput("t4_idle_flush_valid", bus.out_valid, 0);
    checkOutput("t4_idle_flush_busy", bus.busy, 0);
    checkOutput("t4_count", bus.line_count, 1);

    // 5: flush while the queue is full waits for a slot
    doReset();
    for (int i = 0; i < 35; i++) applyStimulus(32'h500 + 32'(i));
    checkOutput("t5_ready_before", bus.in_ready, 1);
    pulseFlush();
    checkOutput("t5_pend_ready", bus.in_ready, 0);
    checkOutput("t5_pend_busy", bus.busy, 1);
    step(); step();
    checkOutput("t5_pend_hold", bus.in_ready, 0);
    checkOutput("t5_line_a", bus.out_data, mkLine(32'h500, 16));
    bus.out_ready = 1'b1;
    step();
    checkOutput("t5_ready_after_pop", bus.in_ready, 1);
    checkOutput("t5_line_b", bus.out_data, mkLine(32'h510, 16));
    step();
    checkOutput("t5_partial", bus.out_data, mkLine(32'h520, 3));
    checkOutput("t5_p_nwords", bus.out_nwords, 3);
    checkOutput("t5_p_last", bus.out_last, 1);
    step();
    bus.out_ready = 1'b0;
    checkOutput("t5_count", bus.line_count, 3);
    checkOutput("t5_busy", bus.busy, 0);

    // 6: reset mid-job discards queued and partial data
    doReset();
    for (int i = 0; i < 23; i++) applyStimulus(32'h6F0 + 32'(i));
    checkOutput("t6_queued", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", bus.out_valid, 0);
    checkOutput("t6_rst_busy", bus.busy, 0);
    checkOutput("t6_rst_data", bus.out_data, 512'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("t6_ready", bus.in_ready, 1);
    for (int i = 0; i < 16; i++) applyStimulus(32'h600 + 32'(i));
    checkOutput("t6_line", bus.out_data, mkLine(32'h600, 16));
    checkOutput("t6_nwords", bus.out_nwords, 16);
    checkOutput("t6_last", bus.out_last, 0);
    checkOutput("t6_count", bus.line_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
